// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants, FSM encoding and immediate helper
// for the multicycle CPU fetch path.
package cpu_isa_pkg;

    localparam int IMM_W = 16;

    localparam logic [5:0] OPC_J   = 6'b000001;
    localparam logic [5:0] OPC_JAL = 6'b000010;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    function automatic logic [31:0] sext_imm(input logic [31:0] instr);
        return {{(32-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bundle: instruction memory, control FSM handshake,
// JAL link write and status outputs.
interface ifetch_unit_if;

    logic        fetch_en;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic [31:0] ir;
    logic        ir_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic        instr_done;
    logic        br_taken;
    logic        link_we;
    logic [4:0]  link_addr;
    logic [31:0] link_data;
    logic        halted;
    logic [31:0] instr_count;

    modport master (
        input  fetch_en, imem_instr, instr_done, br_taken,
        output imem_pc, ir, ir_valid, pc, pc_plus1,
        output link_we, link_addr, link_data, halted, instr_count
    );

    modport slave (
        output fetch_en, imem_instr, instr_done, br_taken,
        input  imem_pc, ir, ir_valid, pc, pc_plus1,
        input  link_we, link_addr, link_data, halted, instr_count
    );

endinterface

// File: rtl/ifetch_next_pc.sv
// Combinational next-PC logic: sequential flow, J, JAL and
// taken branches, all as word-index arithmetic modulo 2^32.
module ifetch_next_pc
    import cpu_isa_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] ir,
    input  logic        br_taken,
    output logic [31:0] pc_plus1,
    output logic [31:0] next_pc,
    output logic        is_jal
);

    logic [5:0] opc;
    logic       is_j;

    assign opc      = ir[31:26];
    assign is_j     = (opc == OPC_J);
    assign is_jal   = (opc == OPC_JAL);
    assign pc_plus1 = pc + 32'd1;

    always_comb begin
        next_pc = pc_plus1;
        unique case (1'b1)
            is_j, is_jal, br_taken: next_pc = pc_plus1 + sext_imm(ir);
            default: ;
        endcase
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC/IR registers, fetch/retire FSM,
// retire counter and JAL link write. Optional HALT_ON_NOP_EN.
module ifetch_unit
    import cpu_isa_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [4:0]  LINK_REG = 5'd31
) (
    input logic          clk,
    input logic          rst_n,
    ifetch_unit_if.master bus
);

    logic [1:0]  state;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        ir_valid_q;
    logic [31:0] cnt_q;
    logic        link_we_q;
    logic [31:0] link_data_q;

    logic [31:0] pc_plus1;
    logic [31:0] next_pc;
    logic        is_jal;
    logic        fetch_go;
    logic        halt_go;
    logic        latch;
    logic        retire;

    ifetch_next_pc u_next_pc (
        .pc       (pc_q),
        .ir       (ir_q),
        .br_taken (bus.br_taken),
        .pc_plus1 (pc_plus1),
        .next_pc  (next_pc),
        .is_jal   (is_jal)
    );

    assign fetch_go = (state == S_FETCH) && bus.fetch_en;
    assign retire   = (state == S_HOLD) && bus.instr_done;

`ifdef HALT_ON_NOP_EN
    assign halt_go    = fetch_go && (bus.imem_instr == 32'h0);
    assign bus.halted = (state == S_HALT);
`else
    assign halt_go    = 1'b0;
    assign bus.halted = 1'b0;
`endif

    // A NOP that halts is never latched as a live instruction
    assign latch = fetch_go && !halt_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= 32'h0;
            ir_valid_q  <= 1'b0;
            cnt_q       <= 32'h0;
            link_we_q   <= 1'b0;
            link_data_q <= 32'h0;
        end else begin
            link_we_q <= 1'b0;
            unique case (1'b1)
                halt_go: begin
                    state <= S_HALT;
                end
                latch: begin
                    state      <= S_HOLD;
                    ir_q       <= bus.imem_instr;
                    ir_valid_q <= 1'b1;
                end
                retire: begin
                    state      <= S_FETCH;
                    pc_q       <= next_pc;
                    ir_valid_q <= 1'b0;
                    cnt_q      <= cnt_q + 32'd1;
                    if (is_jal) begin
                        link_we_q   <= 1'b1;
                        link_data_q <= pc_plus1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_pc     = pc_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus1    = pc_plus1;
    assign bus.ir          = ir_q;
    assign bus.ir_valid    = ir_valid_q;
    assign bus.instr_count = cnt_q;
    assign bus.link_we     = link_we_q;
    assign bus.link_addr   = LINK_REG;
    assign bus.link_data   = link_data_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: per-cycle model compare plus
// literal checks; second instance covers RESET_PC wrap.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fe = 1'b0;
    logic [31:0] ins = 32'h0;
    logic        dn = 1'b0;
    logic        br = 1'b0;
    logic        checking = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    ifetch_unit_if b0 ();
    ifetch_unit_if b1 ();

    assign b0.fetch_en   = fe;
    assign b0.imem_instr = ins;
    assign b0.instr_done = dn;
    assign b0.br_taken   = br;
    assign b1.fetch_en   = fe;
    assign b1.imem_instr = ins;
    assign b1.instr_done = dn;
    assign b1.br_taken   = br;

    ifetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    ifetch_unit #(.RESET_PC(32'hFFFFFFFF), .LINK_REG(5'd31)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an instruction is either held (m_v) or not; retire applies spec rules
    logic [31:0] m_pc, m_ir, m_cnt, m_ld;
    logic        m_v, m_lwe, m_halt;

    function automatic logic [31:0] model_next(input logic [31:0] p,
                                               input logic [31:0] w,
                                               input logic b);
        logic [31:0] imm;
        logic        jump;
        imm  = 32'($signed(w[15:0]));
        jump = (w[31:26] == 6'd1) || (w[31:26] == 6'd2) || b;
        return jump ? p + 32'd1 + imm : p + 32'd1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'd0; m_ir <= 32'd0; m_cnt <= 32'd0; m_ld <= 32'd0;
            m_v <= 1'b0; m_lwe <= 1'b0; m_halt <= 1'b0;
        end else begin
            m_lwe <= 1'b0;
            if (m_halt) begin
            end else if (!m_v) begin
                if (fe) begin
`ifdef HALT_ON_NOP_EN
                    if (ins == 32'h0) m_halt <= 1'b1;
                    else begin m_ir <= ins; m_v <= 1'b1; end
`else
                    m_ir <= ins; m_v <= 1'b1;
`endif
                end
            end else if (dn) begin
                m_pc  <= model_next(m_pc, m_ir, br);
                m_v   <= 1'b0;
                m_cnt <= m_cnt + 32'd1;
                if (m_ir[31:26] == 6'd2) begin
                    m_lwe <= 1'b1;
                    m_ld  <= m_pc + 32'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("imem_pc", b0.imem_pc, m_pc);
            chk("pc", b0.pc, m_pc);
            chk("pc_plus1", b0.pc_plus1, m_pc + 32'd1);
            chk("ir", b0.ir, m_ir);
            chk("ir_valid", {31'b0, b0.ir_valid}, {31'b0, m_v});
            chk("instr_count", b0.instr_count, m_cnt);
            chk("link_we", {31'b0, b0.link_we}, {31'b0, m_lwe});
            chk("link_addr", {27'b0, b0.link_addr}, 32'd31);
            chk("halted", {31'b0, b0.halted}, {31'b0, m_halt});
            if (m_lwe) chk("link_data", b0.link_data, m_ld);
        end
    end

    task automatic step(input logic f, input logic [31:0] w, input logic d, input logic b);
        fe = f; ins = w; dn = d; br = b;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc", b0.pc, 32'd0);
        chk("rst_ir", b0.ir, 32'd0);
        chk("rst_valid", {31'b0, b0.ir_valid}, 32'd0);
        chk("rst_link_data", b0.link_data, 32'd0);
        chk("rst_pc_wrap", b1.pc, 32'hFFFFFFFF);
        rst_n = 1'b1;
        checking = 1'b1;

        step(1'b1, 32'hE400FFFF, 1'b0, 1'b0);
        chk("fetch_ir", b0.ir, 32'hE400FFFF);
        chk("fetch_valid", {31'b0, b0.ir_valid}, 32'd1);
        chk("fetch_pc", b0.pc, 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("retire_pc", b0.pc, 32'd1);
        chk("retire_cnt", b0.instr_count, 32'd1);
        chk("wrap_pc", b1.pc, 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("done_in_fetch", b0.instr_count, 32'd1);

        step(1'b1, 32'h0400000A, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("j_to_12", b0.pc, 32'd12);
        step(1'b1, 32'h8400FFFD, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("br_taken", b0.pc, 32'd10);
        step(1'b1, 32'h04000001, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h8400FFFD, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("br_not_taken", b0.pc, 32'd13);
        step(1'b1, 32'h04000004, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h04000002, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("j_pc", b0.pc, 32'd21);
        chk("j_no_link", {31'b0, b0.link_we}, 32'd0);

        step(1'b1, 32'h0400FFF3, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("j_to_9", b0.pc, 32'd9);
        step(1'b1, 32'h08000004, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("jal_pc", b0.pc, 32'd14);
        chk("jal_we", {31'b0, b0.link_we}, 32'd1);
        chk("jal_addr", {27'b0, b0.link_addr}, 32'd31);
        chk("jal_data", b0.link_data, 32'd10);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("jal_we_drop", {31'b0, b0.link_we}, 32'd0);

        step(1'b1, 32'h04000008, 1'b0, 1'b0);
        step(1'b1, 32'h0, 1'b1, 1'b0);
        chk("both_pc", b0.pc, 32'd23);
        chk("both_valid", {31'b0, b0.ir_valid}, 32'd0);

        step(1'b1, 32'h0, 1'b0, 1'b0);
        repeat (10) step(1'b1, 32'h0, 1'b0, 1'b0);
        chk("nop_pc", b0.pc, 32'd23);
        chk("nop_cnt", b0.instr_count, 32'd10);
`ifdef HALT_ON_NOP_EN
        chk("nop_halted", {31'b0, b0.halted}, 32'd1);
        chk("nop_valid", {31'b0, b0.ir_valid}, 32'd0);
        rst_n = 1'b0;
        #2;
        chk("halt_rst", {31'b0, b0.halted}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
`else
        chk("nop_ir", b0.ir, 32'h0);
        chk("nop_valid", {31'b0, b0.ir_valid}, 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("nop_retire", b0.pc, 32'd24);
`endif

        step(1'b1, 32'hE400FFFF, 1'b0, 1'b0);
        chk("pre_rst_valid", {31'b0, b0.ir_valid}, 32'd1);
        rst_n = 1'b0;
        #2;
        chk("async_valid", {31'b0, b0.ir_valid}, 32'd0);
        chk("async_pc", b0.pc, 32'd0);
        chk("async_ir", b0.ir, 32'd0);
        chk("async_cnt", b0.instr_count, 32'd0);
        chk("async_pc_wrap", b1.pc, 32'hFFFFFFFF);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        step(1'b1, 32'h0400FFFF, 1'b0, 1'b0);
        chk("post_rst_fetch", {31'b0, b0.ir_valid}, 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("j_self", b0.pc, 32'd0);
        step(1'b1, 32'h0400FFFD, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("j_back_wrap", b0.pc, 32'hFFFFFFFE);
        step(1'b1, 32'hE400FFFF, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'hE400FFFF, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("seq_wrap", b0.pc, 32'd0);
        chk("final_cnt", b0.instr_count, 32'd4);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
